// File: rtl/trade_report_tx_pkg.sv
// Shared constants and helpers for the trade report transmitter.
// This covers the frame layout, the byte codes and the FSM state encodings.
package trade_report_tx_pkg;

  localparam int          TR_DATA_W   = 16;
  localparam int          FRAME_LEN   = 5;
  localparam logic [7:0]  SYNC_DEF    = 8'hA5;
  localparam logic [7:0]  BUY_DEF     = 8'h42;
  localparam logic [7:0]  SELL_DEF    = 8'h53;

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_SEND     = 2'd1;
  localparam logic [1:0]  ST_GAP      = 2'd2;

  function automatic logic [7:0] frame_chk(input logic [7:0] code,
                                           input logic [TR_DATA_W-1:0] data);
    return code ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on the rising edge of a level input.
module rise_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic in_d;

  always_comb begin
    in_d = in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/trade_report_tx.sv
// Turns buy/sell events into 5-byte frames (SYNC, CODE, DATA hi, DATA lo, CHK)
// for the UART TX FIFO, with a one-deep pending slot and a saturating drop counter.
module trade_report_tx
  import trade_report_tx_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
  parameter logic [7:0] BUY_CODE  = BUY_DEF,
  parameter logic [7:0] SELL_CODE = SELL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              buy_signal,
  input  logic              sell_signal,
  input  logic [DATA_W-1:0] event_data,
  input  logic              tx_full,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic              busy,
  output logic [7:0]        drop_count
);

  logic buy_evt;
  logic sell_evt;

  rise_edge_detect u_buy_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (buy_signal),
    .pulse   (buy_evt)
  );

  rise_edge_detect u_sell_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (sell_signal),
    .pulse   (sell_evt)
  );

  logic [1:0]        state_q,     state_d;
  logic [2:0]        idx_q,       idx_d;
  logic [7:0]        code_q,      code_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              pend_vld_q,  pend_vld_d;
  logic [7:0]        pend_code_q, pend_code_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [7:0]        drop_q,      drop_d;
  logic [7:0]        w_data_q,    w_data_d;
  logic              wr_q,        wr_d;

  logic              legal_evt;
  logic              drop_evt;
  logic              frame_last;
  logic [7:0]        evt_code;
  logic [7:0]        cur_byte;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    code_d      = code_q;
    data_d      = data_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    pend_data_d = pend_data_q;
    drop_d      = drop_q;
    w_data_d    = w_data_q;
    wr_d        = 1'b0;

    legal_evt  = buy_evt ^ sell_evt;
    drop_evt   = buy_evt & sell_evt;
    evt_code   = buy_evt ? BUY_CODE : SELL_CODE;
    frame_last = (idx_q == 3'(FRAME_LEN - 1));

    case (idx_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = code_q;
      3'd2:    cur_byte = data_q[15:8];
      3'd3:    cur_byte = data_q[7:0];
      default: cur_byte = frame_chk(code_q, data_q);
    endcase

    case (state_q)
      ST_IDLE: begin
        if (legal_evt) begin
          code_d  = evt_code;
          data_d  = event_data;
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_full) begin
          wr_d     = 1'b1;
          w_data_d = cur_byte;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!frame_last) begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_SEND;
        end else if (pend_vld_q) begin
          code_d     = pend_code_q;
          data_d     = pend_data_q;
          pend_vld_d = 1'b0;
          idx_d      = 3'd0;
          state_d    = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The slot is free either when empty or when it is being drained this very cycle.
    if (legal_evt && (state_q != ST_IDLE)) begin
      if (!pend_vld_q || ((state_q == ST_GAP) && frame_last)) begin
        pend_vld_d  = 1'b1;
        pend_code_d = evt_code;
        pend_data_d = event_data;
      end else begin
        drop_evt = 1'b1;
      end
    end

    if (drop_evt && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      code_q      <= 8'd0;
      data_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= 8'd0;
      pend_data_q <= '0;
      drop_q      <= 8'd0;
      w_data_q    <= 8'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      data_q      <= data_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      pend_data_q <= pend_data_d;
      drop_q      <= drop_d;
      w_data_q    <= w_data_d;
      wr_q        <= wr_d;
    end
  end

  assign w_data     = w_data_q;
  assign wr_uart    = wr_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != ST_IDLE) | pend_vld_q;

endmodule

// File: tb/tb_trade_report_tx.sv
// Scoreboard bench for trade_report_tx: expected frame bytes are queued at stimulus
// time and popped by a monitor on every write strobe.
module tb_trade_report_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        buy_signal;
  logic        sell_signal;
  logic [15:0] event_data;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        busy;
  logic [7:0]  drop_count;

  trade_report_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .buy_signal  (buy_signal),
    .sell_signal (sell_signal),
    .event_data  (event_data),
    .tx_full     (tx_full),
    .w_data      (w_data),
    .wr_uart     (wr_uart),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         fails     = 0;
  int         cyc       = 0;
  int         n_writes  = 0;
  logic [7:0] exp_q[$];
  int         wr_cyc[$];
  logic [7:0] last_w    = 8'd0;
  logic [7:0] mon_exp;

  always @(posedge clk) cyc++;

  // Monitor: scoreboard pop on every strobe, and w_data must hold between strobes.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_w = 8'd0;
    end else if (wr_uart) begin
      n_writes++;
      wr_cyc.push_back(cyc);
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got %02h, expected no write", w_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (w_data !== mon_exp) begin
          fails++;
          $display("FAIL frame_byte: got %02h, expected %02h (cycle %0d)", w_data, mon_exp, cyc);
        end
      end
      last_w = w_data;
    end else begin
      tests_run++;
      if (w_data !== last_w) begin
        fails++;
        $display("FAIL w_data_hold: got %02h, expected %02h", w_data, last_w);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] code, input logic [15:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(code);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(code ^ d[15:8] ^ d[7:0]);
  endtask

  task automatic do_reset();
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
    event_data  = 16'h0000;
    tx_full     = 1'b0;
    reset_n     = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    exp_q.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy && !wr_uart && exp_q.size() == 0) break;
      tick(1);
    end
    tests_run++;
    if (busy || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_done: busy=%0b bytes_left=%0d, expected busy=0 bytes_left=0", name, busy, exp_q.size());
    end
  endtask

  task automatic wait_writes(input string name, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_writes >= target) break;
      @(negedge clk);
      #1;
    end
    tests_run++;
    if (n_writes != target) begin
      fails++;
      $display("FAIL %s_wait: writes=%0d, expected %0d", name, n_writes, target);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    tests_run += 4;
    if (w_data !== 8'h00)     begin fails++; $display("FAIL reset_w_data: got %02h, expected 00", w_data); end
    if (wr_uart !== 1'b0)     begin fails++; $display("FAIL reset_wr_uart: got %0b, expected 0", wr_uart); end
    if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
    if (drop_count !== 8'h00) begin fails++; $display("FAIL reset_drop: got %02h, expected 00", drop_count); end
    do_reset();
  endtask

  task automatic test_buy();
    int t0;
    do_reset();
    t0 = cyc;
    buy_signal = 1'b1;
    event_data = 16'h1234;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h42); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h64);
    tick(1);
    buy_signal = 1'b0;
    event_data = 16'hDEAD;
    tests_run++;
    if (busy !== 1'b1) begin fails++; $display("FAIL buy_busy: got %0b, expected 1", busy); end
    wait_done("buy", 40);
    tests_run++;
    if (wr_cyc.size() != 5) begin
      fails++;
      $display("FAIL buy_count: got %0d writes, expected 5", wr_cyc.size());
    end else begin
      tests_run += 2;
      if (wr_cyc[0] != t0 + 2)  begin fails++; $display("FAIL buy_first_lat: got cycle %0d, expected %0d", wr_cyc[0], t0 + 2); end
      if (wr_cyc[4] != t0 + 10) begin fails++; $display("FAIL buy_last_lat: got cycle %0d, expected %0d", wr_cyc[4], t0 + 10); end
    end
  endtask

  task automatic test_sell();
    do_reset();
    sell_signal = 1'b1;
    event_data  = 16'h00FF;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h53); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hAC);
    tick(1);
    sell_signal = 1'b0;
    wait_done("sell", 40);
    tests_run++;
    if (drop_count !== 8'h00) begin fails++; $display("FAIL sell_drop: got %02h, expected 00", drop_count); end
  endtask

  task automatic test_stall();
    int base;
    do_reset();
    base = n_writes;
    buy_signal = 1'b1;
    event_data = 16'hBEEF;
    push_frame(8'h42, 16'hBEEF);
    tick(1);
    buy_signal = 1'b0;
    wait_writes("stall_pre", base + 2, 20);
    tx_full = 1'b1;
    tick(20);
    tests_run += 2;
    if (n_writes != base + 2) begin fails++; $display("FAIL stall_hold: writes=%0d, expected %0d", n_writes, base + 2); end
    if (busy !== 1'b1)        begin fails++; $display("FAIL stall_busy: got %0b, expected 1", busy); end
    tx_full = 1'b0;
    wait_done("stall", 40);
    tests_run++;
    if (n_writes != base + 5) begin fails++; $display("FAIL stall_total: writes=%0d, expected %0d", n_writes, base + 5); end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = n_writes;
    buy_signal = 1'b1; event_data = 16'h1111;
    push_frame(8'h42, 16'h1111);
    tick(1); buy_signal = 1'b0; tick(2);
    buy_signal = 1'b1; event_data = 16'h2222;
    push_frame(8'h42, 16'h2222);
    tick(1); buy_signal = 1'b0; tick(1);
    buy_signal = 1'b1; event_data = 16'h3333;
    tick(1); buy_signal = 1'b0;
    wait_done("b2b", 60);
    tests_run += 2;
    if (drop_count !== 8'd1)   begin fails++; $display("FAIL b2b_drop: got %0d, expected 1", drop_count); end
    if (n_writes != base + 10) begin fails++; $display("FAIL b2b_total: writes=%0d, expected %0d", n_writes, base + 10); end
  endtask

  task automatic test_illegal();
    int base;
    do_reset();
    base = n_writes;
    buy_signal = 1'b1; sell_signal = 1'b1; event_data = 16'h4444;
    tick(1);
    buy_signal = 1'b0; sell_signal = 1'b0;
    tick(8);
    tests_run += 3;
    if (n_writes != base)     begin fails++; $display("FAIL illegal_nowrite: writes=%0d, expected %0d", n_writes, base); end
    if (drop_count !== 8'd1)  begin fails++; $display("FAIL illegal_drop: got %0d, expected 1", drop_count); end
    if (busy !== 1'b0)        begin fails++; $display("FAIL illegal_busy: got %0b, expected 0", busy); end
    for (int i = 1; i < 300; i++) begin
      buy_signal = 1'b1; sell_signal = 1'b1;
      tick(1);
      buy_signal = 1'b0; sell_signal = 1'b0;
      tick(1);
      if (i == 99) begin
        tests_run++;
        if (drop_count !== 8'd100) begin fails++; $display("FAIL drop_100: got %0d, expected 100", drop_count); end
      end
    end
    tests_run += 2;
    if (drop_count !== 8'hFF) begin fails++; $display("FAIL drop_sat: got %02h, expected ff", drop_count); end
    if (n_writes != base)     begin fails++; $display("FAIL drop_nowrite: writes=%0d, expected %0d", n_writes, base); end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    base = n_writes;
    buy_signal = 1'b1; event_data = 16'h5AC3;
    push_frame(8'h42, 16'h5AC3);
    tick(1); buy_signal = 1'b0;
    wait_writes("mid_pre", base + 3, 20);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    tests_run += 4;
    if (wr_uart !== 1'b0)     begin fails++; $display("FAIL mid_wr_uart: got %0b, expected 0", wr_uart); end
    if (w_data !== 8'h00)     begin fails++; $display("FAIL mid_w_data: got %02h, expected 00", w_data); end
    if (busy !== 1'b0)        begin fails++; $display("FAIL mid_busy: got %0b, expected 0", busy); end
    if (drop_count !== 8'h00) begin fails++; $display("FAIL mid_drop: got %02h, expected 00", drop_count); end
    tick(2);
    reset_n = 1'b1;
    tick(2);
    sell_signal = 1'b1; event_data = 16'h7E81;
    push_frame(8'h53, 16'h7E81);
    tick(1); sell_signal = 1'b0;
    wait_done("mid_fresh", 40);
    tests_run++;
    if (n_writes != base + 8) begin fails++; $display("FAIL mid_total: writes=%0d, expected %0d", n_writes, base + 8); end
  endtask

  initial begin
    reset_n     = 1'b0;
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
    event_data  = 16'h0000;
    tx_full     = 1'b0;
    tick(1);
    test_reset();
    test_buy();
    test_sell();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
